// File: rtl/pulse_width_meter.sv
// Measures the length in clk cycles of each high pulse on q_in and hands the
// widths out through a one-entry valid/ready slot, with a pulse count and sticky overflow.
module pulse_width_meter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             clr,
  output logic [WIDTH-1:0] width_data,
  output logic             width_valid,
  input  logic             width_ready,
  output logic [CNT_W-1:0] pulse_count,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RUN_MAX = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] run_q, run_d;
  logic [WIDTH-1:0] width_data_q, width_data_d;
  logic             width_valid_q, width_valid_d;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_d;
  logic             ovf_q, ovf_d;
  logic             complete;
  logic             xfer;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    sat_inc = (v == RUN_MAX) ? v : v + WIDTH'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    width_data_d  = width_data_q;
    width_valid_d = width_valid_q;
    pulse_count_d = pulse_count_q;
    ovf_d         = ovf_q;
    complete      = (state_q == HIGH) && !q_in;
    xfer          = width_valid_q && width_ready;

    case (state_q)
      // ARM discards any pulse that was already in progress when measuring began
      ARM: begin
        run_d = '0;
        if (!q_in) state_d = IDLE;
      end
      IDLE: begin
        if (q_in) begin
          state_d = HIGH;
          run_d   = WIDTH'(1);
        end
      end
      HIGH: begin
        if (q_in) begin
          run_d = sat_inc(run_q);
        end else begin
          state_d = IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ARM;
        run_d   = '0;
      end
    endcase

    if (complete) begin
      pulse_count_d = pulse_count_q + CNT_W'(1);
      if (!width_valid_q || width_ready) begin
        width_data_d  = run_q;
        width_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (xfer) begin
      width_valid_d = 1'b0;
    end

    // clr wins over any completion or transfer on the same edge; width_data is kept
    if (clr) begin
      state_d       = ARM;
      run_d         = '0;
      width_valid_d = 1'b0;
      pulse_count_d = '0;
      ovf_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARM;
      run_q         <= '0;
      width_data_q  <= '0;
      width_valid_q <= 1'b0;
      pulse_count_q <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      width_data_q  <= width_data_d;
      width_valid_q <= width_valid_d;
      pulse_count_q <= pulse_count_d;
      ovf_q         <= ovf_d;
    end
  end

  assign width_data  = width_data_q;
  assign width_valid = width_valid_q;
  assign pulse_count = pulse_count_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: drives q_in as the AND-stage output would.
module tb_pulse_width_meter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             q_in;
  logic             clr;
  logic [WIDTH-1:0] width_data;
  logic             width_valid;
  logic             width_ready;
  logic [CNT_W-1:0] pulse_count;
  logic             ovf;

  int checks;
  int failures;

  pulse_width_meter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_in       (q_in),
    .clr        (clr),
    .width_data (width_data),
    .width_valid(width_valid),
    .width_ready(width_ready),
    .pulse_count(pulse_count),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int d, input int v, input int c, input int o);
    chk({tag, ".width_data"}, 32'(width_data), 32'(d));
    chk({tag, ".width_valid"}, 32'(width_valid), 32'(v));
    chk({tag, ".pulse_count"}, 32'(pulse_count), 32'(c));
    chk({tag, ".ovf"}, 32'(ovf), 32'(o));
  endtask

  // clr edge, then one idle edge so the meter moves ARM -> IDLE
  task automatic do_clr(input string tag, input int keep_data);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_all(tag, keep_data, 0, 0, 0);
    q_in = 1'b0;
    step();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    q_in        = 1'b0;
    clr         = 1'b0;
    width_ready = 1'b0;
    #3;
    chk_all("reset", 0, 0, 0, 0);
    steps(2);
    rst_n = 1'b1;
    step();

    // 10-cycle pulse, consumer ready
    width_ready = 1'b1;
    q_in = 1'b1;
    steps(10);
    q_in = 1'b0;
    step();
    chk_all("w10", 10, 1, 1, 0);
    step();
    chk("w10_drain.valid", 32'(width_valid), 32'd0);
    chk("w10_drain.data", 32'(width_data), 32'd10);

    // single-cycle pulse
    q_in = 1'b1;
    step();
    q_in = 1'b0;
    chk("w1_pre.valid", 32'(width_valid), 32'd0);
    step();
    chk_all("w1", 1, 1, 2, 0);
    step();
    chk("w1_drain.valid", 32'(width_valid), 32'd0);

    // widths 3 then 5 with consumer stalled
    do_clr("clr_a", 1);
    width_ready = 1'b0;
    q_in = 1'b1;
    steps(3);
    q_in = 1'b0;
    step();
    chk_all("w3", 3, 1, 1, 0);
    step();
    q_in = 1'b1;
    steps(5);
    q_in = 1'b0;
    step();
    chk_all("w5_drop", 3, 1, 2, 1);
    step();
    chk("stall_hold.data", 32'(width_data), 32'd3);
    width_ready = 1'b1;
    step();
    chk("stall_drain.valid", 32'(width_valid), 32'd0);
    chk("stall_drain.ovf", 32'(ovf), 32'd1);

    // saturation at 255
    do_clr("clr_b", 3);
    q_in = 1'b1;
    steps(300);
    chk("sat_mid.valid", 32'(width_valid), 32'd0);
    q_in = 1'b0;
    step();
    chk_all("sat", 255, 1, 1, 0);
    step();

    // reset in the middle of a pulse, released with q_in still high
    q_in = 1'b1;
    steps(4);
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    steps(6);
    chk_all("rst_hi", 0, 0, 0, 0);
    q_in = 1'b0;
    step();
    chk_all("rst_arm", 0, 0, 0, 0);
    q_in = 1'b1;
    steps(2);
    q_in = 1'b0;
    step();
    chk_all("w2", 2, 1, 1, 0);
    step();

    // completion on the same edge as a transfer
    do_clr("clr_c", 2);
    width_ready = 1'b0;
    q_in = 1'b1;
    steps(4);
    q_in = 1'b0;
    step();
    chk_all("w4", 4, 1, 1, 0);
    step();
    q_in = 1'b1;
    steps(7);
    q_in = 1'b0;
    width_ready = 1'b1;
    step();
    chk_all("w7_xfer", 7, 1, 2, 0);
    width_ready = 1'b0;
    step();
    chk("w7_hold.data", 32'(width_data), 32'd7);
    chk("w7_hold.valid", 32'(width_valid), 32'd1);

    // clr overrides a simultaneous transfer and clears a set ovf
    q_in = 1'b1;
    steps(2);
    q_in = 1'b0;
    step();
    chk("ovf_set", 32'(ovf), 32'd1);
    width_ready = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_all("clr_final", 7, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
